// File: rtl/spaceship_locator.sv
// spaceship_locator: per-frame spaceship position/angle state plus registered sprite-ROM lookup request.
// Ports: CLK/RST_N (async active-low) clock and reset; hc/vc VGA column/row;
//   btn_left/right/up/down move, btn_cw/ccw rotate (debounced levels);
//   is_SS_in_pixel/SS_hc/SS_vc/SS_angle sprite lookup request; ss_valid ROM-aligned valid;
//   ss_x/ss_y sprite top-left; frame_tick one-cycle frame-update strobe.
// Build option: define SS_WRAP_EN to wrap the position at screen edges instead of clamping.
module spaceship_locator #(
  parameter int SS_SIZE   = 36,
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int START_X   = 302,
  parameter int START_Y   = 222,
  parameter int STEP      = 2,
  parameter int ROT_DIV   = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [9:0] hc,
  input  logic [9:0] vc,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_cw,
  input  logic       btn_ccw,
  output logic       is_SS_in_pixel,
  output logic [9:0] SS_hc,
  output logic [9:0] SS_vc,
  output logic [3:0] SS_angle,
  output logic       ss_valid,
  output logic [9:0] ss_x,
  output logic [9:0] ss_y,
  output logic       frame_tick
);
  localparam int CW = ROT_DIV > 1 ? $clog2(ROT_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ROT_DIV - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;
  localparam logic [10:0] X_MAX = 11'(H_VISIBLE - SS_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_VISIBLE - SS_SIZE);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic [3:0] angle_q, angle_d;
  logic [0:0] rot_q, rot_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d;
  logic edge_q, tick_q, tick_d;
  logic hit_q, hit_d, valid_q;
  logic [9:0] shc_q, shc_d, svc_q, svc_d;
  logic in_box, single;
  logic [3:0] angle_step;

  // One axis of motion; the sign bit of the 11-bit sum flags an underflow past zero.
  function automatic logic [9:0] move(input logic [9:0] p, input logic dec, input logic inc,
                                      input logic [10:0] pmax);
    logic [10:0] n;
    n = {1'b0, p} + ((inc & ~dec) ? 11'(STEP) : (dec & ~inc) ? -11'(STEP) : 11'd0);
`ifdef SS_WRAP_EN
    move = n[10] ? pmax[9:0] : ($signed(n) > $signed(pmax)) ? 10'd0 : n[9:0];
`else
    move = n[10] ? 10'd0 : ($signed(n) > $signed(pmax)) ? pmax[9:0] : n[9:0];
`endif
  endfunction

  assign single     = btn_cw ^ btn_ccw;
  assign angle_step = angle_q + (btn_cw ? 4'd1 : 4'd15);
  assign tick_d     = (vc == 10'(V_VISIBLE)) & ~edge_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    angle_d = angle_q;
    rot_d = rot_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (tick_q) begin
      x_d = move(x_q, btn_left, btn_right, X_MAX);
      y_d = move(y_q, btn_up, btn_down, Y_MAX);
      if (rot_q == IDLE) begin
        if (single) begin
          angle_d = angle_step;
          cnt_d = '0;
          rot_d = HELD;
          dir_d = btn_cw;
        end
      end else if (single && btn_cw == dir_q) begin
        // Repeat a step every ROT_DIV ticks while the same button stays held.
        angle_d = (cnt_q == CNT_LAST) ? angle_step : angle_q;
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end else begin
        rot_d = IDLE;
        cnt_d = '0;
      end
    end
  end

  // 11-bit compares keep x+SS_SIZE from overflowing near the right edge.
  assign in_box = ({1'b0, hc} >= {1'b0, x_q}) && ({1'b0, hc} < {1'b0, x_q} + 11'(SS_SIZE)) &&
                  ({1'b0, vc} >= {1'b0, y_q}) && ({1'b0, vc} < {1'b0, y_q} + 11'(SS_SIZE));

  always_comb begin
    hit_d = in_box;
    shc_d = in_box ? hc - x_q : 10'd0;
    svc_d = in_box ? vc - y_q : 10'd0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_q <= 10'(START_X);
      y_q <= 10'(START_Y);
      angle_q <= 4'd0;
      rot_q <= IDLE;
      cnt_q <= '0;
      dir_q <= 1'b0;
      edge_q <= 1'b0;
      tick_q <= 1'b0;
      hit_q <= 1'b0;
      shc_q <= 10'd0;
      svc_q <= 10'd0;
      valid_q <= 1'b0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      angle_q <= angle_d;
      rot_q <= rot_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
      edge_q <= (vc == 10'(V_VISIBLE));
      tick_q <= tick_d;
      hit_q <= hit_d;
      shc_q <= shc_d;
      svc_q <= svc_d;
      valid_q <= hit_q;
    end
  end

  assign is_SS_in_pixel = hit_q;
  assign SS_hc = shc_q;
  assign SS_vc = svc_q;
  assign SS_angle = angle_q;
  assign ss_valid = valid_q;
  assign ss_x = x_q;
  assign ss_y = y_q;
  assign frame_tick = tick_q;
endmodule
